// File: rtl/mandelbrot_iter_sched_if.sv
// mandelbrot_iter_sched_if: job (cx, cy, limit, tag) and result handshake channels
interface mandelbrot_iter_sched_if #(
  parameter int D  = 4,
  parameter int F  = 28,
  parameter int CW = 16,
  parameter int TW = 20
);
  localparam int W = D + F;
  logic                in_valid, in_ready, out_valid, out_ready, escaped;
  logic signed [W-1:0] cx, cy;
  logic [CW-1:0]       max_iter, iter_count;
  logic [TW-1:0]       tag_in, tag_out;
  modport master (
    output in_valid, cx, cy, max_iter, tag_in, out_ready,
    input  in_ready, out_valid, escaped, iter_count, tag_out
  );
  modport slave (
    input  in_valid, cx, cy, max_iter, tag_in, out_ready,
    output in_ready, out_valid, escaped, iter_count, tag_out
  );
endinterface

// File: rtl/mandelbrot_iter_sched.sv
// mandelbrot_iter_sched: per-pixel z <- z^2 + c iterator sharing one multiplier over three cycles
module mandelbrot_iter_sched #(
  parameter int D  = 4,
  parameter int F  = 28,
  parameter int CW = 16,
  parameter int TW = 20
) (
  input logic clk,
  input logic rst_n,
  mandelbrot_iter_sched_if.slave bus
);
  localparam int W = D + F;
  localparam logic signed [W+1:0] TWO  = (W+2)'(2) << F;
  localparam logic signed [W+1:0] FOUR = (W+2)'(4) << F;
  typedef enum logic [2:0] {IDLE, MUL_XX, MUL_YY, MUL_XY, UPDATE, DONE} state_t;
  state_t state, state_nx;
  logic signed [W-1:0] cx_q, cy_q, zx, zy, xx, yy, xy, ma, mb, p;
  logic signed [2*W-1:0] prod;
  logic signed [W+1:0] sum, nzx, nzy;
  logic [CW-1:0] n, iter, iter_inc, count;
  logic [TW-1:0] tag;
  logic esc, rej, big, zesc;
  function automatic logic oor(input logic signed [W+1:0] v);
    return v > TWO || v < -TWO;
  endfunction
  // Extra headroom bits: xx + yy can reach 8.0, outside the D.F range.
  always_comb begin
    ma = state == MUL_YY ? zy : zx;
    mb = state == MUL_XX ? zx : zy;
    prod = (2*W)'(ma) * (2*W)'(mb);
    p = W'(prod >>> F);
    sum = (W+2)'(xx) + (W+2)'(yy);
    nzx = (W+2)'(xx) - (W+2)'(yy) + (W+2)'(cx_q);
    nzy = ((W+2)'(xy) <<< 1) + (W+2)'(cy_q);
    big = sum > FOUR;
    zesc = oor(nzx) || oor(nzy);
    rej = oor((W+2)'(bus.cx)) || oor((W+2)'(bus.cy));
    iter_inc = iter + CW'(1);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = (rej || bus.max_iter == '0) ? DONE : MUL_XX;
      MUL_XX:  state_nx = MUL_YY;
      MUL_YY:  state_nx = MUL_XY;
      MUL_XY:  state_nx = UPDATE;
      UPDATE:  state_nx = (big || zesc || iter_inc == n) ? DONE : MUL_XX;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cx_q <= '0;
      cy_q <= '0;
      zx <= '0;
      zy <= '0;
      xx <= '0;
      yy <= '0;
      xy <= '0;
      n <= '0;
      iter <= '0;
      count <= '0;
      tag <= '0;
      esc <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.in_valid) begin
          cx_q <= bus.cx;
          cy_q <= bus.cy;
          n <= bus.max_iter;
          tag <= bus.tag_in;
          zx <= '0;
          zy <= '0;
          iter <= '0;
          count <= '0;
          esc <= rej;
        end
        MUL_XX: xx <= p;
        MUL_YY: yy <= p;
        MUL_XY: xy <= p;
        UPDATE: if (big || zesc) begin
          esc <= 1'b1;
          count <= big ? iter : iter_inc;
        end else begin
          zx <= W'(nzx);
          zy <= W'(nzy);
          iter <= iter_inc;
          count <= iter_inc;
        end
        default: ;
      endcase
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.escaped = esc;
  assign bus.iter_count = count;
  assign bus.tag_out = tag;
endmodule

// File: tb/tb_mandelbrot_iter_sched.sv
// tb_mandelbrot_iter_sched: directed and random jobs checked against an arithmetic reference model
module tb_mandelbrot_iter_sched;
  localparam int D = 4, F = 28, CW = 16, TW = 20, W = D + F;
  localparam longint ONE = 64'sd1 <<< F;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  bit exp_esc;
  int exp_cnt, exp_lat, exp_tag;
  mandelbrot_iter_sched_if #(.D(D), .F(F), .CW(CW), .TW(TW)) bus();
  mandelbrot_iter_sched #(.D(D), .F(F), .CW(CW), .TW(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint mag(input longint v);
    return v < 0 ? -v : v;
  endfunction
  // Latency is counted in clock edges after the acceptance edge.
  function automatic void ref_model(input longint x, input longint y, input int lim,
                                    output bit e, output int cnt, output int lat);
    longint zx = 0, zy = 0, xx, yy, xy, nx, ny;
    e = 0;
    cnt = lim;
    lat = 4 * lim;
    if (mag(x) > 2 * ONE || mag(y) > 2 * ONE) begin
      e = 1;
      cnt = 0;
      lat = 0;
      return;
    end
    for (int k = 0; k < lim; k++) begin
      xx = (zx * zx) >>> F;
      yy = (zy * zy) >>> F;
      xy = (zx * zy) >>> F;
      if (xx + yy > 4 * ONE) begin
        e = 1; cnt = k; lat = 4 * (k + 1);
        return;
      end
      nx = xx - yy + x;
      ny = 2 * xy + y;
      if (mag(nx) > 2 * ONE || mag(ny) > 2 * ONE) begin
        e = 1; cnt = k + 1; lat = 4 * (k + 1);
        return;
      end
      zx = nx;
      zy = ny;
    end
  endfunction
  task automatic accept(input longint x, input longint y, input int lim, input int tg);
    int w = 0;
    ref_model(x, y, lim, exp_esc, exp_cnt, exp_lat);
    exp_tag = tg;
    bus.cx = W'(x);
    bus.cy = W'(y);
    bus.max_iter = CW'(lim);
    bus.tag_in = TW'(tg);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", longint'(w < 1000), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic collect();
    int lat = 0;
    while (!bus.out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid", bus.out_valid, 1);
    check("escaped", bus.escaped, exp_esc);
    check("iter_count", bus.iter_count, exp_cnt);
    check("tag_out", bus.tag_out, exp_tag);
    if (exp_lat == 0) check("latency_imm", longint'(lat <= 1), 1);
    else check("latency", lat, exp_lat);
  endtask
  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after", bus.in_ready, 1);
    check("valid_drop", bus.out_valid, 0);
  endtask
  task automatic run_job(input longint x, input longint y, input int lim, input int tg);
    accept(x, y, lim, tg);
    collect();
    release_out();
  endtask
  function automatic longint rand_coord();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return 2 * ONE;
    if (sel == 1) return -2 * ONE;
    return longint'($urandom_range(0, 32'h48000000)) - 64'sh24000000;
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.cx = '0;
    bus.cy = '0;
    bus.max_iter = '0;
    bus.tag_in = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_escaped", bus.escaped, 0);
    check("rst_count", bus.iter_count, 0);
    check("rst_tag", bus.tag_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    run_job(0, 0, 10, 20'h00001);
    run_job(ONE, ONE, 100, 20'h00002);
    run_job(-2 * ONE, 0, 50, 20'h00003);
    run_job(5 * ONE / 2, 0, 7, 20'h00004);
    run_job(ONE / 4, 0, 0, 20'hABCDE);
    run_job(2 * ONE, 2 * ONE, 9, 20'h00005);
    run_job(2 * ONE + 1, 0, 9, 20'h00006);
    run_job(0, -2 * ONE - 1, 9, 20'h00007);
    // Backpressure: result must hold and new offers must be ignored.
    accept(ONE / 4, 0, 5, 20'h12345);
    collect();
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.cx = W'($urandom_range(0, 32'h10000000));
      bus.cy = W'($urandom_range(0, 32'h10000000));
      bus.max_iter = CW'($urandom_range(1, 9));
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_escaped", bus.escaped, exp_esc);
      check("bp_count", bus.iter_count, exp_cnt);
      check("bp_tag", bus.tag_out, exp_tag);
    end
    bus.in_valid = 1'b0;
    release_out();
    run_job(-ONE / 2, ONE / 2, 20, 20'h54321);
    // Reset mid-job discards the job and clears every output.
    accept(0, 0, 10, 20'hFEDCB);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_escaped", bus.escaped, 0);
    check("mid_rst_count", bus.iter_count, 0);
    check("mid_rst_tag", bus.tag_out, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    run_job(0, 0, 10, 20'h0BEEF);
    for (int j = 0; j < 40; j++)
      run_job(rand_coord(), rand_coord(), $urandom_range(0, 40), $urandom_range(0, 20'hFFFFF));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
